// File: rtl/regbank_pkg.sv
// Shared types for the register-bank write arbiter: source-select
// encoding, FSM state encoding, widths and the latched request record.
package regbank_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_REG  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_ZERO = 2'b11
  } src_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dst;
    src_sel_t             src;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    imm;
  } wr_req_t;

endpackage

// File: rtl/regbank_write_arb_arb2.sv
// Two-input arbiter with one-hot grant (bit 0 = A, bit 1 = B).
// REGBANK_RR_ARB_EN defined: round-robin, pointer flips to the other
// requester after every acceptance. Undefined: fixed priority, A wins.
module arb2 (
`ifdef REGBANK_RR_ARB_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef REGBANK_RR_ARB_EN
  logic ptr;  // 0: A favoured, 1: B favoured

  // Pointer moves past whoever was just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

  // Favoured requester first, the other one otherwise.
  always_comb begin
    grant = '0;
    if (!ptr) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end
`else
  // A always beats B.
  always_comb begin
    grant    = '0;
    grant[0] = req[0];
    grant[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/regbank_write_arb.sv
// Register-bank write arbiter: accepts writes from two requesters and
// sequences regBank selects (SETUP) then enable (WRITE), two cycles per
// write. Optional macro REGBANK_RR_ARB_EN selects round-robin arbitration.
module regbank_write_arb
  import regbank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_dst,
  input  logic [1:0]           a_src,
  input  logic [REG_IDX_W-1:0] a_rd,
  input  logic [DATA_W-1:0]    a_imm,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_dst,
  input  logic [1:0]           b_src,
  input  logic [REG_IDX_W-1:0] b_rd,
  input  logic [DATA_W-1:0]    b_imm,
  output logic [1:0]           ms,
  output logic [REG_IDX_W-1:0] rs,
  output logic                 e,
  output logic [REG_IDX_W-1:0] rd_sel,
  output logic [DATA_W-1:0]    imm,
  output logic                 done,
  output logic                 done_id,
  output logic                 busy
);

  state_t     state, state_nxt;
  logic       open_slot;
  logic       accept;
  logic [1:0] grant;
  wr_req_t    a_req, b_req, cur;
  logic       owner;
  logic       e_q;

  assign a_req.dst = a_dst;
  assign a_req.src = src_sel_t'(a_src);
  assign a_req.rd  = a_rd;
  assign a_req.imm = a_imm;
  assign b_req.dst = b_dst;
  assign b_req.src = src_sel_t'(b_src);
  assign b_req.rd  = b_rd;
  assign b_req.imm = b_imm;

  arb2 u_arb (
`ifdef REGBANK_RR_ARB_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
`endif
    .req     ({b_valid, a_valid}),
    .grant   (grant)
  );

  // Next state; a new request can be taken in IDLE and in WRITE.
  always_comb begin
    state_nxt = state;
    open_slot = 1'b0;
    unique case (state)
      ST_IDLE: begin
        open_slot = 1'b1;
        if (a_valid || b_valid) state_nxt = ST_SETUP;
      end
      ST_SETUP: state_nxt = ST_WRITE;
      ST_WRITE: begin
        open_slot = 1'b1;
        state_nxt = (a_valid || b_valid) ? ST_SETUP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = open_slot & (a_valid | b_valid);

  // Ready is forced low while reset is held so it clears asynchronously.
  assign a_ready = rst_n & open_slot & grant[0];
  assign b_ready = rst_n & open_slot & grant[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Latch the winning request on acceptance; selects only move entering SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      owner <= 1'b0;
    end else if (accept) begin
      cur   <= grant[1] ? b_req : a_req;
      owner <= grant[1];
    end
  end

  // Registered write enable, high for the whole WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= 1'b0;
    else        e_q <= (state_nxt == ST_WRITE);
  end

  assign ms      = cur.src;
  assign rs      = cur.dst;
  assign rd_sel  = cur.rd;
  assign imm     = cur.imm;
  assign e       = e_q;
  assign done    = e_q;
  assign done_id = owner;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_regbank_write_arb.sv
// Self-checking bench for regbank_write_arb: per-scenario tasks plus a
// scoreboard of expected writes checked whenever a write completes.
module tb_regbank_write_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [2:0] a_dst, a_rd, b_dst, b_rd;
  logic [1:0] a_src, b_src;
  logic [7:0] a_imm, b_imm;
  logic [1:0] ms;
  logic [2:0] rs, rd_sel;
  logic       e, done, done_id, busy;
  logic [7:0] imm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       id;
    logic [1:0] src;
    logic [2:0] dst;
    logic [2:0] rd;
    logic [7:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t x;

  logic        prev_setup = 1'b0;
  logic [15:0] prev_sel   = '0;

  regbank_write_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_dst   (a_dst),
    .a_src   (a_src),
    .a_rd    (a_rd),
    .a_imm   (a_imm),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_dst   (b_dst),
    .b_src   (b_src),
    .b_rd    (b_rd),
    .b_imm   (b_imm),
    .ms      (ms),
    .rs      (rs),
    .e       (e),
    .rd_sel  (rd_sel),
    .imm     (imm),
    .done    (done),
    .done_id (done_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Write monitor: every enable pulse must match the head of the scoreboard
  // and the selects must equal those seen during the preceding SETUP cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (e) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got rs=%0d ms=%b want no write", rs, ms);
        end else begin
          x = sb.pop_front();
          if ({done, done_id, ms, rs, rd_sel, imm} !== {1'b1, x.id, x.src, x.dst, x.rd, x.imm}) begin
            bad++;
            $display("FAIL write_data got done=%b id=%b ms=%b rs=%0d rd_sel=%0d imm=%h want done=1 id=%b ms=%b rs=%0d rd_sel=%0d imm=%h",
                     done, done_id, ms, rs, rd_sel, imm, x.id, x.src, x.dst, x.rd, x.imm);
          end
        end
        total++;
        if ({prev_setup, prev_sel} !== {1'b1, ms, rs, rd_sel, imm}) begin
          bad++;
          $display("FAIL sel_stable got prev_setup=%b prev_sel=%h want 1 %h",
                   prev_setup, prev_sel, {ms, rs, rd_sel, imm});
        end
      end else begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL done_without_e got done=%b want 0", done);
        end
      end
      prev_setup = busy & ~e;
      prev_sel   = {ms, rs, rd_sel, imm};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [2:0] dst, input logic [1:0] src,
                       input logic [2:0] rd, input logic [7:0] im);
    a_valid = v; a_dst = dst; a_src = src; a_rd = rd; a_imm = im;
  endtask

  task automatic set_b(input logic v, input logic [2:0] dst, input logic [1:0] src,
                       input logic [2:0] rd, input logic [7:0] im);
    b_valid = v; b_dst = dst; b_src = src; b_rd = rd; b_imm = im;
  endtask

  task automatic push(input logic id, input logic [1:0] src, input logic [2:0] dst,
                      input logic [2:0] rd, input logic [7:0] im);
    exp_t t;
    t.id = id; t.src = src; t.dst = dst; t.rd = rd; t.imm = im;
    sb.push_back(t);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_a(1'b1, 3'd7, 2'd1, 3'd7, 8'hFF);
    set_b(1'b1, 3'd6, 2'd2, 3'd5, 8'hEE);
    @(posedge clk); #2;
    total++;
    if ({a_ready, b_ready, e, done, done_id, busy, ms, rs, rd_sel, imm} !== 22'd0) begin
      bad++;
      $display("FAIL reset_state got %h want 0",
               {a_ready, b_ready, e, done, done_id, busy, ms, rs, rd_sel, imm});
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    set_a(1'b1, 3'd3, 2'b10, 3'd0, 8'h5A);
    push(1'b0, 2'b10, 3'd3, 3'd0, 8'h5A);
    @(negedge clk);
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready got %b want 10", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0;
    set_b(1'b1, 3'd1, 2'b10, 3'd0, 8'hC3);  // withdrawn before it can be taken
    @(negedge clk);
    total++;
    if ({busy, e, b_ready} !== 3'b100) begin
      bad++;
      $display("FAIL single_setup got busy,e,b_ready=%b want 100", {busy, e, b_ready});
    end
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({e, done, ms, rs, imm} !== {1'b1, 1'b1, 2'b10, 3'd3, 8'h5A}) begin
      bad++;
      $display("FAIL single_write got e=%b done=%b ms=%b rs=%0d imm=%h want 1 1 10 3 5a",
               e, done, ms, rs, imm);
    end
    tick();
    tick();
    total++;
    if ({busy, e} !== 2'b00) begin
      bad++;
      $display("FAIL withdrawn_idle got busy,e=%b want 00", {busy, e});
    end
  endtask

  task automatic test_reg_copy();
    tick();
    set_b(1'b1, 3'd7, 2'b01, 3'd2, 8'h33);
    push(1'b1, 2'b01, 3'd7, 3'd2, 8'h33);
    @(negedge clk);
    total++;
    if ({a_ready, b_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b_ready got %b want 01", {a_ready, b_ready});
    end
    tick();
    b_valid = 1'b0;
    wait_drain("b_copy");
    set_a(1'b1, 3'd5, 2'b01, 3'd5, 8'h00);
    push(1'b0, 2'b01, 3'd5, 3'd5, 8'h00);
    tick();
    a_valid = 1'b0;
    wait_drain("self_copy");
  endtask

  task automatic test_zero();
    tick();
    set_a(1'b1, 3'd0, 2'b11, 3'd6, 8'hFF);
    push(1'b0, 2'b11, 3'd0, 3'd6, 8'hFF);
    tick();
    a_valid = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if ({e, done, ms, rs} !== {1'b1, 1'b1, 2'b11, 3'd0}) begin
      bad++;
      $display("FAIL zero_write got e=%b done=%b ms=%b rs=%0d want 1 1 11 0", e, done, ms, rs);
    end
    tick();
    @(negedge clk);
    total++;
    if ({e, done} !== 2'b00) begin
      bad++;
      $display("FAIL zero_one_cycle got e,done=%b want 00", {e, done});
    end
  endtask

  task automatic test_both();
    logic [0:9] ear, ebr, ee;
    int ncyc;
    tick();
    set_a(1'b1, 3'd1, 2'b00, 3'd0, 8'h11);
    set_b(1'b1, 3'd6, 2'b10, 3'd1, 8'hB6);
`ifdef REGBANK_RR_ARB_EN
    ncyc = 8;
    ear = 10'b1000100000;
    ebr = 10'b0010000000;
    ee  = 10'b0010101000;
    push(1'b0, 2'b00, 3'd1, 3'd0, 8'h11);
    push(1'b1, 2'b10, 3'd6, 3'd1, 8'hB6);
    push(1'b0, 2'b10, 3'd2, 3'd3, 8'h22);
`else
    ncyc = 10;
    ear = 10'b1010100000;
    ebr = 10'b0000001000;
    ee  = 10'b0010101010;
    push(1'b0, 2'b00, 3'd1, 3'd0, 8'h11);
    push(1'b0, 2'b10, 3'd2, 3'd3, 8'h22);
    push(1'b0, 2'b01, 3'd4, 3'd6, 8'h44);
    push(1'b1, 2'b10, 3'd6, 3'd1, 8'hB6);
`endif
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      total++;
      if ({a_ready, b_ready, e} !== {ear[c], ebr[c], ee[c]}) begin
        bad++;
        $display("FAIL both_cycle%0d got a_ready,b_ready,e=%b want %b",
                 c, {a_ready, b_ready, e}, {ear[c], ebr[c], ee[c]});
      end
      tick();
`ifdef REGBANK_RR_ARB_EN
      if (c == 0) set_a(1'b1, 3'd2, 2'b10, 3'd3, 8'h22);
      if (c == 2) b_valid = 1'b0;
      if (c == 4) a_valid = 1'b0;
`else
      if (c == 0) set_a(1'b1, 3'd2, 2'b10, 3'd3, 8'h22);
      if (c == 2) set_a(1'b1, 3'd4, 2'b01, 3'd6, 8'h44);
      if (c == 4) a_valid = 1'b0;
      if (c == 6) b_valid = 1'b0;
`endif
    end
    wait_drain("both");
  endtask

  task automatic test_reset_mid_write();
    tick();
    set_a(1'b1, 3'd5, 2'b10, 3'd0, 8'h77);
    push(1'b0, 2'b10, 3'd5, 3'd0, 8'h77);
    tick();
    a_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({e, done, done_id, busy, ms, rs, rd_sel, imm} !== 20'd0) begin
      bad++;
      $display("FAIL reset_abort got %h want 0", {e, done, done_id, busy, ms, rs, rd_sel, imm});
    end
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({e, busy} !== 2'b00) begin
        bad++;
        $display("FAIL post_abort%0d got e,busy=%b want 00", c, {e, busy});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a();
    test_reg_copy();
    test_zero();
    test_both();
    test_reset_mid_write();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover got pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
